if_id_pipe_reg: RTL and testbench
=================================

Name: if_id_pipe_reg

Overview:
Parametrised IF→ID pipeline register, the successor to the fixed 32-bit PC/instruction latch.
- Adds a valid/ready handshake, synchronous flush for branch/jump squash, and an optional 2-entry skid buffer.
- With the skid buffer, ID back-pressure never creates a combinational ready path back into IF.
- Sits between the fetch unit and the decoder. It carries the PC and instruction as independent-width fields.

Parameters:
- PC_W, 32, width of the PC field.
- INSTR_W, 32, width of the instruction field.
- RESET_PC, 32'h3000, PC value loaded on reset (PC_W bits).
- NOP_INSTR, 0, instruction presented when the stage is empty, flushed or reset.
- SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with pass-through ready.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of all held entries (branch/jump taken)
- in_valid  in  1  IF presents a fetched instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  PC_W  PC of the fetched instruction
- in_instr  in  INSTR_W  fetched instruction
- out_valid  out  1  ID-side entry valid
- out_ready  in  1  ID consumes the entry this cycle
- out_pc  out  PC_W  PC of the head entry
- out_instr  out  INSTR_W  head instruction; NOP_INSTR when out_valid=0
- occupancy  out  2  entries held (0..2)

Behaviour:
- accept = in_valid & in_ready; consume = out_valid & out_ready.
- Storage: main register (pc, instr, valid) drives the outputs. Skid register (pc, instr, valid) is present only when SKID_EN=1.
- Async reset (rstn=0):
  - state=EMPTY; main_pc=RESET_PC; main_instr=NOP_INSTR; all valid bits 0; skid contents 0.
  - Outputs during and after reset: out_valid=0, out_pc=RESET_PC, out_instr=NOP_INSTR, occupancy=0, in_ready=1.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- SKID_EN=1 state machine. Registers update on the clk edge; in_ready = (state != FULL), taken only from the state flops.
  - EMPTY: accept → BUSY, main ← in.
  - BUSY, accept & consume → BUSY, main ← in.
  - BUSY, accept & !consume → FULL, skid ← in, main holds.
  - BUSY, !accept & consume → EMPTY.
  - BUSY, otherwise → hold.
  - FULL: consume → BUSY, main ← skid, skid.valid ← 0. No accept is possible in FULL.
- SKID_EN=0:
  - in_ready = !out_valid | out_ready (combinational).
  - States are EMPTY/BUSY only; FULL is unreachable; occupancy ≤ 1.
- Latency and throughput: an accepted entry appears on out_* the next cycle. Sustained throughput is 1 entry/cycle when out_ready=1.
- Ordering: strict FIFO. The skid entry is always younger than main.
- Flush (synchronous, highest priority):
  - Next state is EMPTY; all valid bits clear; main_instr ← NOP_INSTR; main_pc holds its last value.
  - An in_valid entry in the flush cycle is dropped, even if in_ready=1.
  - A consume in the flush cycle is still seen by ID; the flush squashes only what remains.
  - in_ready=1 on the cycle after the flush.
- out_instr = main.valid ? main_instr : NOP_INSTR. out_pc always equals main_pc.
- When out_valid=1 and out_ready=0, out_pc and out_instr are stable until consume.
- occupancy = main.valid + skid.valid.

Test Plan:
- Reset check: hold rstn=0 mid-stream with 2 entries held → out_valid=0, out_pc=0x3000, out_instr=0, occupancy=0, in_ready=1 asynchronously; no entries reappear after release.
- Streaming: feed PCs 0x3000, 0x3004, 0x3008 with out_ready=1 → each appears one cycle later, in order, out_valid continuous, occupancy=1.
- Back-pressure (SKID_EN=1):
  - Drop out_ready while feeding 0x3000, 0x3004 → occupancy=2, in_ready=0, out_pc holds 0x3000.
  - Raise out_ready → 0x3000 then 0x3004 delivered, in_ready=1 one cycle after the first consume.
- Flush in FULL: flush=1 with in_valid=1 (pc 0x300C) and out_ready=0 → next cycle out_valid=0, out_instr=NOP_INSTR, occupancy=0; 0x300C never appears on out_pc.
- Flush with consume: flush=1, out_ready=1, occupancy=2 → head consumed that cycle, skid entry discarded, occupancy=0 next cycle.
- SKID_EN=0, INSTR_W=16, PC_W=16:
  - out_ready=0 with out_valid=1 → in_ready=0 in the same cycle.
  - out_ready=1 → in_ready=1 and a new entry replaces the head next cycle; occupancy never exceeds 1.

Source files
------------

// File: rtl/if_id_pipe_reg.sv
// IF->ID pipeline register: PC/instruction pair with valid/ready handshake,
// synchronous flush and an optional 2-entry skid buffer that registers in_ready.
module if_id_pipe_reg #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [PC_W-1:0]    RESET_PC  = PC_W'(32'h3000),
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter bit                 SKID_EN   = 1'b1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [1:0]         occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state_reg;
    logic [PC_W-1:0]      main_pc_reg;
    logic [INSTR_W-1:0]   main_instr_reg;
    logic                 main_valid_reg;
    logic [PC_W-1:0]      skid_pc_reg;
    logic [INSTR_W-1:0]   skid_instr_reg;
    logic                 skid_valid_reg;

    logic accept;
    logic consume;

    assign accept  = in_valid & in_ready;
    assign consume = main_valid_reg & out_ready;

    // With the skid buffer, ready depends only on state so ID stall never reaches IF combinationally.
    generate
        if (SKID_EN) begin : g_skid_ready
            assign in_ready = (state_reg != FULL);
        end else begin : g_pass_ready
            assign in_ready = !main_valid_reg || out_ready;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= EMPTY;
            main_pc_reg    <= RESET_PC;
            main_instr_reg <= NOP_INSTR;
            main_valid_reg <= 1'b0;
            skid_pc_reg    <= '0;
            skid_instr_reg <= '0;
            skid_valid_reg <= 1'b0;
        end else if (flush) begin
            // main_pc_reg deliberately keeps its last value
            state_reg      <= EMPTY;
            main_instr_reg <= NOP_INSTR;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        state_reg      <= BUSY;
                        main_pc_reg    <= in_pc;
                        main_instr_reg <= in_instr;
                        main_valid_reg <= 1'b1;
                    end
                end
                BUSY: begin
                    if (accept && consume) begin
                        main_pc_reg    <= in_pc;
                        main_instr_reg <= in_instr;
                    end else if (accept && SKID_EN) begin
                        state_reg      <= FULL;
                        skid_pc_reg    <= in_pc;
                        skid_instr_reg <= in_instr;
                        skid_valid_reg <= 1'b1;
                    end else if (consume) begin
                        state_reg      <= EMPTY;
                        main_valid_reg <= 1'b0;
                    end
                end
                FULL: begin
                    if (consume) begin
                        state_reg      <= BUSY;
                        main_pc_reg    <= skid_pc_reg;
                        main_instr_reg <= skid_instr_reg;
                        skid_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= EMPTY;
                    main_valid_reg <= 1'b0;
                    skid_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = main_valid_reg;
    assign out_pc    = main_pc_reg;
    assign out_instr = main_valid_reg ? main_instr_reg : NOP_INSTR;
    assign occupancy = 2'(main_valid_reg) + 2'(skid_valid_reg);

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: a skid instance (32-bit) and a pass-through instance (16-bit),
// each with a queue scoreboard filled on accept and drained on consume.
module tb_if_id_pipe_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_pc, a_in_instr, a_out_pc, a_out_instr;
    logic [1:0]  a_occ;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0] b_in_pc, b_in_instr, b_out_pc, b_out_instr;
    logic [1:0]  b_occ;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t q_a[$];
    ent_t q_b[$];
    ent_t ea, eb;

    if_id_pipe_reg #(
        .PC_W(32), .INSTR_W(32), .RESET_PC(32'h3000), .NOP_INSTR(32'h0), .SKID_EN(1'b1)
    ) dut_a (
        .clk(clk), .rstn(rstn), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pc(a_in_pc), .in_instr(a_in_instr),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc), .out_instr(a_out_instr),
        .occupancy(a_occ)
    );

    if_id_pipe_reg #(
        .PC_W(16), .INSTR_W(16), .RESET_PC(16'h3000), .NOP_INSTR(16'h0), .SKID_EN(1'b0)
    ) dut_b (
        .clk(clk), .rstn(rstn), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pc(b_in_pc), .in_instr(b_in_instr),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc), .out_instr(b_out_instr),
        .occupancy(b_occ)
    );

    // Scoreboard monitors: sample mid-cycle, pop on consume, squash on flush, push on accept.
    always @(negedge clk) begin
        if (!rstn) begin
            q_a.delete();
        end else begin
            checks++;
            if (a_out_valid !== (q_a.size() != 0)) begin
                errors++;
                $display("FAIL a_sb_valid got %0b exp %0b", a_out_valid, q_a.size() != 0);
            end
            if (a_out_valid && a_out_ready && q_a.size() != 0) begin
                ea = q_a.pop_front();
                checks++;
                if (a_out_pc !== ea.pc || a_out_instr !== ea.instr) begin
                    errors++;
                    $display("FAIL a_sb_data got pc %h instr %h exp pc %h instr %h",
                             a_out_pc, a_out_instr, ea.pc, ea.instr);
                end else begin
                    $display("a consume pc %h instr %h", a_out_pc, a_out_instr);
                end
            end
            if (a_flush) q_a.delete();
            else if (a_in_valid && a_in_ready) q_a.push_back('{pc: a_in_pc, instr: a_in_instr});
        end
    end

    always @(negedge clk) begin
        if (!rstn) begin
            q_b.delete();
        end else begin
            checks++;
            if (b_out_valid !== (q_b.size() != 0)) begin
                errors++;
                $display("FAIL b_sb_valid got %0b exp %0b", b_out_valid, q_b.size() != 0);
            end
            if (b_out_valid && b_out_ready && q_b.size() != 0) begin
                eb = q_b.pop_front();
                checks++;
                if (b_out_pc !== eb.pc[15:0] || b_out_instr !== eb.instr[15:0]) begin
                    errors++;
                    $display("FAIL b_sb_data got pc %h instr %h exp pc %h instr %h",
                             b_out_pc, b_out_instr, eb.pc[15:0], eb.instr[15:0]);
                end else begin
                    $display("b consume pc %h instr %h", b_out_pc, b_out_instr);
                end
            end
            if (b_flush) q_b.delete();
            else if (b_in_valid && b_in_ready)
                q_b.push_back('{pc: {16'h0, b_in_pc}, instr: {16'h0, b_in_instr}});
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_pc = '0; a_in_instr = '0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_pc = '0; b_in_instr = '0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_pc !== 32'h3000 || a_out_instr !== 32'h0 ||
            a_occ !== 2'd0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_a got v%0b pc %h i %h occ %0d rdy %0b exp v0 pc 00003000 i 0 occ 0 rdy 1",
                     a_out_valid, a_out_pc, a_out_instr, a_occ, a_in_ready);
        end
        checks++;
        if (b_out_valid !== 1'b0 || b_out_pc !== 16'h3000 || b_out_instr !== 16'h0 ||
            b_occ !== 2'd0 || b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_b got v%0b pc %h i %h occ %0d rdy %0b exp v0 pc 3000 i 0 occ 0 rdy 1",
                     b_out_valid, b_out_pc, b_out_instr, b_occ, b_in_ready);
        end
        rstn = 1'b1;
        // fill to two entries, then reset asynchronously between edges
        next(); a_in_valid = 1; a_in_pc = 32'h3000; a_in_instr = $urandom;
        next(); a_in_pc = 32'h3004; a_in_instr = $urandom;
        next(); a_in_valid = 0; #1;
        checks++;
        if (a_occ !== 2'd2) begin
            errors++;
            $display("FAIL midreset_fill got occ %0d exp 2", a_occ);
        end
        #1 rstn = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_pc !== 32'h3000 || a_out_instr !== 32'h0 ||
            a_occ !== 2'd0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_async got v%0b pc %h i %h occ %0d rdy %0b exp v0 pc 00003000 i 0 occ 0 rdy 1",
                     a_out_valid, a_out_pc, a_out_instr, a_occ, a_in_ready);
        end
        next(); next(); rstn = 1'b1; a_out_ready = 1;
        next(); next(); #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin
            errors++;
            $display("FAIL midreset_after got v%0b occ %0d exp v0 occ 0", a_out_valid, a_occ);
        end
    endtask

    task automatic test_stream();
        next(); a_out_ready = 1; a_in_valid = 1; a_in_pc = 32'h3000; a_in_instr = $urandom;
        for (int i = 1; i <= 3; i++) begin
            next();
            if (i < 3) begin
                a_in_pc = 32'h3000 + 32'(4 * i);
                a_in_instr = $urandom;
            end else begin
                a_in_valid = 0;
            end
            #1;
            checks++;
            if (a_out_valid !== 1'b1 || a_occ !== 2'd1 || a_out_pc !== 32'h3000 + 32'(4 * (i - 1))) begin
                errors++;
                $display("FAIL stream_%0d got v%0b occ %0d pc %h exp v1 occ 1 pc %h",
                         i, a_out_valid, a_occ, a_out_pc, 32'h3000 + 32'(4 * (i - 1)));
            end
        end
        next(); #1;
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain got v%0b exp 0", a_out_valid);
        end
    endtask

    task automatic test_backpressure();
        next(); a_out_ready = 0; a_in_valid = 1; a_in_pc = 32'h3000; a_in_instr = $urandom;
        next(); a_in_pc = 32'h3004; a_in_instr = $urandom; #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_busy_ready got %0b exp 1", a_in_ready);
        end
        for (int i = 0; i < 2; i++) begin
            next(); a_in_valid = 0; #1;
            checks++;
            if (a_occ !== 2'd2 || a_in_ready !== 1'b0 || a_out_pc !== 32'h3000) begin
                errors++;
                $display("FAIL bp_full_%0d got occ %0d rdy %0b pc %h exp occ 2 rdy 0 pc 00003000",
                         i, a_occ, a_in_ready, a_out_pc);
            end
        end
        a_out_ready = 1; #1;
        checks++;
        if (a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_registered_ready got %0b exp 0", a_in_ready);
        end
        next(); #1;
        checks++;
        if (a_out_pc !== 32'h3004 || a_in_ready !== 1'b1 || a_occ !== 2'd1) begin
            errors++;
            $display("FAIL bp_release got pc %h rdy %0b occ %0d exp pc 00003004 rdy 1 occ 1",
                     a_out_pc, a_in_ready, a_occ);
        end
        next(); #1;
        checks++;
        if (a_occ !== 2'd0) begin
            errors++;
            $display("FAIL bp_empty got occ %0d exp 0", a_occ);
        end
    endtask

    task automatic test_flush();
        // flush while FULL with an offered entry and ID stalled
        next(); a_out_ready = 0; a_in_valid = 1; a_in_pc = 32'h3000; a_in_instr = $urandom;
        next(); a_in_pc = 32'h3004; a_in_instr = $urandom;
        next(); a_in_pc = 32'h300C; a_in_instr = $urandom; a_flush = 1;
        next(); a_flush = 0; a_in_valid = 0; #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_instr !== 32'h0 || a_occ !== 2'd0 ||
            a_in_ready !== 1'b1 || a_out_pc !== 32'h3000) begin
            errors++;
            $display("FAIL flush_full got v%0b i %h occ %0d rdy %0b pc %h exp v0 i 0 occ 0 rdy 1 pc 00003000",
                     a_out_valid, a_out_instr, a_occ, a_in_ready, a_out_pc);
        end
        // flush in BUSY drops an entry offered with in_ready=1
        next(); a_in_valid = 1; a_in_pc = 32'h3010; a_in_instr = $urandom;
        next(); a_in_pc = 32'h3014; a_in_instr = $urandom; a_flush = 1; #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_busy_ready got %0b exp 1", a_in_ready);
        end
        next(); a_flush = 0; a_in_valid = 0; #1;
        checks++;
        if (a_occ !== 2'd0 || a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy got occ %0d v%0b exp occ 0 v0", a_occ, a_out_valid);
        end
        // flush coinciding with a consume from FULL
        next(); a_in_valid = 1; a_in_pc = 32'h3020; a_in_instr = $urandom;
        next(); a_in_pc = 32'h3024; a_in_instr = $urandom;
        next(); a_in_valid = 0; #1;
        checks++;
        if (a_occ !== 2'd2) begin
            errors++;
            $display("FAIL flush_cons_fill got occ %0d exp 2", a_occ);
        end
        a_flush = 1; a_out_ready = 1;
        next(); a_flush = 0; a_out_ready = 0; #1;
        checks++;
        if (a_occ !== 2'd0 || a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_cons got occ %0d v%0b exp occ 0 v0", a_occ, a_out_valid);
        end
        next();
    endtask

    task automatic test_noskid();
        next(); b_out_ready = 0; b_in_valid = 1; b_in_pc = 16'h0100; b_in_instr = 16'(
            $urandom);
        next(); b_in_pc = 16'h0104; b_in_instr = 16'($urandom); #1;
        checks++;
        if (b_out_valid !== 1'b1 || b_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL noskid_stall got v%0b rdy %0b exp v1 rdy 0", b_out_valid, b_in_ready);
        end
        b_out_ready = 1; #1;
        checks++;
        if (b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL noskid_passthru got rdy %0b exp 1", b_in_ready);
        end
        next(); b_in_valid = 0; #1;
        checks++;
        if (b_out_pc !== 16'h0104 || b_occ !== 2'd1) begin
            errors++;
            $display("FAIL noskid_replace got pc %h occ %0d exp pc 0104 occ 1", b_out_pc, b_occ);
        end
        for (int i = 0; i < 30; i++) begin
            next();
            b_in_valid = 1'($urandom_range(0, 1));
            b_out_ready = 1'($urandom_range(0, 1));
            b_in_pc = b_in_pc + 16'd2;
            b_in_instr = 16'($urandom);
            #1;
            checks++;
            if (b_occ > 2'd1) begin
                errors++;
                $display("FAIL noskid_occ_%0d got %0d exp <=1", i, b_occ);
            end
        end
        b_in_valid = 0; b_out_ready = 1;
        next(); next();
    endtask

    task automatic test_back_to_back();
        a_in_pc = 32'h4000;
        for (int i = 0; i < 60; i++) begin
            next();
            a_in_valid = 1'($urandom_range(0, 3) != 0);
            a_out_ready = 1'($urandom_range(0, 2) != 0);
            a_flush = ($urandom_range(0, 9) == 0);
            a_in_pc = a_in_pc + 32'd4;
            a_in_instr = $urandom;
            #1;
            checks++;
            if (a_occ > 2'd2 || (a_in_ready !== (a_occ != 2'd2))) begin
                errors++;
                $display("FAIL b2b_%0d got occ %0d rdy %0b", i, a_occ, a_in_ready);
            end
        end
        a_flush = 0; a_in_valid = 0; a_out_ready = 1;
        repeat (3) next();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_noskid();
        test_back_to_back();
        @(negedge clk);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d entries left exp 0/0", q_a.size(), q_b.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
